mac_nch_acc: RTL and testbench
==============================

Name: mac_nch_acc

Overview:
- Parametrised, time-multiplexed multi-channel multiply-accumulator.
- Successor to the single-channel 18x28 MAC used in the FIR/decimator chains.
- Accepts a tagged, channel-indexed sample/coefficient stream and keeps one accumulator per channel.
- Emits a saturated, rounded, channel-tagged result on each channel's last tap; interleaved channels (I/Q, multi-receiver) share one multiplier.

Parameters:
- DW, 18: signed data input width.
- CW, 28: signed coefficient input width.
- NCH, 4: number of channels / accumulators (1..64).
- GUARD, 2: extra accumulator MSBs for summation growth; AW = DW+CW+GUARD.
- OSHIFT, 24: accumulator LSBs dropped by rounding.
- OW, 20: signed output width; requires OSHIFT+OW <= AW.

Ports:
- clk  in  1  master clock, all flops on rising edge.
- rst  in  1  asynchronous active-high reset.
- iv  in  1  input valid; din/cin/ch/first/last sampled only when high.
- din  in  DW  signed data.
- cin  in  CW  signed coefficient.
- ch  in  CHW  channel index, CHW = max(1, clog2(NCH)); values >= NCH are ignored (treated as iv=0).
- first  in  1  first tap of a channel's sum.
- last  in  1  last tap of a channel's sum.
- dout  out  OW  rounded/saturated sum of products.
- och  out  CHW  channel of dout.
- ov  out  1  dout/och/ovf valid, one-cycle pulse per result.
- ovf  out  1  overflow flag for this result.

Behaviour:
- Reset (asynchronous, rst=1): all accumulators, pipeline valids and tags, dout, och, ov and ovf go to 0. Stream restarts cleanly after release; any sum in flight is discarded.
- Pipeline, 4 stages:
  - S1: register inputs and tags.
  - S2: signed product P = din*cin, full DW+CW bits.
  - S3: acc[ch] <= sext(P) + (first ? 0 : acc[ch]).
  - S4: round + saturate, register outputs.
- Latency: sample with last=1 accepted at edge k gives ov=1 during the cycle after edge k+4 (4 clocks).
- Throughput: one sample per clock, any channel order. Back-to-back samples on the same channel must accumulate correctly: S3 read-after-write, no stall, no forwarding bubble.
- iv=0 is a bubble; no accumulator changes.
- first and last on the same sample: result = that single product.
- first without a preceding last on that channel: previous partial sum discarded silently.
- last without first: accumulates onto the existing sum; after output the accumulator is retained, not cleared. Only first clears.
- Accumulator wraps modulo 2^AW; no internal saturation.
- Rounding (default, symmetric, half away from zero):
  - R = acc + (2^(OSHIFT-1) if acc >= 0, else 2^(OSHIFT-1)-1), computed in AW+1 bits.
  - Candidate output = R[OSHIFT+OW-1:OSHIFT].
- Overflow: R bits [AW:OSHIFT+OW-1] not all equal. On overflow:
  - dout = +(2^(OW-1)-1) if the sign of acc is 0, else -(2^(OW-1)-1) (symmetric, never the most-negative code).
  - ovf = 1.
- ovf is per result (not sticky) and is valid only with ov. dout/och/ovf hold their values between ov pulses.

Optional Feature:
- MAC_CONV_ROUND_EN.
- Defined: convergent rounding (round half to even). Add 2^(OSHIFT-1)-1 + acc[OSHIFT] regardless of sign; overflow and saturation rules are unchanged.
- Undefined: symmetric rounding as above.

Decomposition:
- Package mac_pkg holds:
  - Functions: clog2, sat_pos(OW), sat_neg(OW), round constant as function of (sign, lsb, OSHIFT).
  - Localparams: AW, CHW.
- One sub-module mac_round_sat: combinational round + overflow detect + saturate, AW in, OW + ovf out, instantiated in S4.
- The accumulator bank is a register array in the top.

Test Plan:
- Test values use defaults with NCH=4.
- Single-tap: ch=2, first=last=1, din=1000, cin=2^24 -> 4 clocks later ov=1, och=2, dout=1000, ovf=0.
- Rounding ties: product +2^23 -> dout=+1; product -2^23 -> dout=-1. With MAC_CONV_ROUND_EN: +2^23 -> 0, 3*2^23 -> +2.
- Interleave: 8 taps each on ch0/ch1 alternating every clock, din=1/-1, cin=2^24 -> ch0 dout=8, ch1 dout=-8, each result 4 clocks after its last.
- Same-channel back-to-back: 16 consecutive taps ch3, din=3, cin=2^24 -> dout=48; then immediate first on ch3 with din=5 single-tap -> dout=5.
- Saturation: 8 taps din=131071, cin=2^27-1 -> ovf=1, dout=524287; same with din=-131072 -> ovf=1, dout=-524287.
- Reset mid-sum: assert rst after 3 taps on ch1, release, send last-only tap din=7, cin=2^24 -> dout=7 (accumulator was cleared); ov low throughout reset.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the multi-channel MAC.
//   clog2/ch_width     : index width helpers
//   sat_pos/sat_neg    : symmetric saturation codes for an OW-bit signed output
//   round_const        : rounding addend applied before dropping OSHIFT LSBs
//   AW, CHW            : accumulator and channel-index widths of the default build
// Build option: define MAC_CONV_ROUND_EN for convergent (half-to-even) rounding;
// otherwise rounding is symmetric, half away from zero.
package mac_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // A single channel still gets a 1-bit index.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    localparam int AW  = 18 + 28 + 2;
    localparam int CHW = ch_width(4);

    // +(2^(ow-1)-1), returned wide; callers cast to their width.
    function automatic logic [127:0] sat_pos(input int ow);
        logic [127:0] one;
        one = 128'd1;
        return (one << (ow - 1)) - one;
    endfunction

    // -(2^(ow-1)-1): the most-negative code is never produced.
    function automatic logic [127:0] sat_neg(input int ow);
        return ~sat_pos(ow) + 128'd1;
    endfunction

    function automatic logic [127:0] round_const(input logic sign, input logic lsb,
                                                 input int oshift);
        logic [127:0] half;
        logic [127:0] sym;
        logic [127:0] conv;
        half = 128'd1 << (oshift - 1);
        // Negative values get half-1 so exact ties move away from zero.
        sym  = sign ? half - 128'd1 : half;
        // Ties resolve toward the even quotient.
        conv = half - 128'd1 + {127'd0, lsb};
`ifdef MAC_CONV_ROUND_EN
        return conv;
`else
        return sym;
`endif
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round, overflow detect and symmetric saturate.
//   acc  in  IW  signed accumulator value
//   dout out OW  rounded value, or +/-(2^(OW-1)-1) on overflow
//   ovf  out 1   rounded value did not fit in OW bits
module mac_round_sat
    import mac_pkg::*;
#(
    parameter int IW     = 48,
    parameter int OW     = 20,
    parameter int OSHIFT = 24
) (
    input  logic [IW-1:0] acc,
    output logic [OW-1:0] dout,
    output logic          ovf
);

    localparam logic signed [IW:0] QMAX = (IW + 1)'(sat_pos(OW));
    localparam logic signed [IW:0] QMIN = (IW + 1)'(sat_neg(OW) - 128'd1);
    localparam logic [OW-1:0]      SATP = OW'(sat_pos(OW));
    localparam logic [OW-1:0]      SATN = OW'(sat_neg(OW));

    logic signed [IW:0] rnd;
    logic signed [IW:0] quo;

    // One extra bit so adding the rounding constant can never wrap.
    assign rnd = $signed({acc[IW-1], acc}) +
                 $signed((IW + 1)'(round_const(acc[IW-1], acc[OSHIFT], OSHIFT)));
    assign quo = rnd >>> OSHIFT;

    // Range compare on the full quotient is equivalent to the top bits not all matching.
    assign ovf  = (quo > QMAX) || (quo < QMIN);
    assign dout = ovf ? (acc[IW-1] ? SATN : SATP) : quo[OW-1:0];

endmodule

// File: rtl/mac_nch_acc.sv
// Time-multiplexed multi-channel multiply-accumulator, one shared multiplier.
//   clk, rst          clock, asynchronous active-high reset
//   iv, din, cin, ch  tagged sample stream; ch >= NCH is dropped
//   first, last       first tap clears the channel sum, last tap emits a result
//   dout, och, ov     rounded/saturated result, its channel, one-cycle valid
//   ovf               result saturated (qualified by ov)
// Build option MAC_CONV_ROUND_EN selects convergent rounding (see mac_pkg).
module mac_nch_acc
    import mac_pkg::*;
#(
    parameter int DW     = 18,
    parameter int CW     = 28,
    parameter int NCH    = 4,
    parameter int GUARD  = 2,
    parameter int OSHIFT = 24,
    parameter int OW     = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iv,
    input  logic [DW-1:0]                din,
    input  logic [CW-1:0]                cin,
    input  logic [ch_width(NCH)-1:0]     ch,
    input  logic                         first,
    input  logic                         last,
    output logic [OW-1:0]                dout,
    output logic [ch_width(NCH)-1:0]     och,
    output logic                         ov,
    output logic                         ovf
);

    localparam int ACC_W = DW + CW + GUARD;
    localparam int PW    = DW + CW;
    localparam int CH_W  = ch_width(NCH);
    localparam logic [CH_W:0] NCH_LIM = (CH_W + 1)'(NCH);

    logic                     accept;
    // S1
    logic                     v1, f1, l1;
    logic [CH_W-1:0]          ch1;
    logic signed [DW-1:0]     d1;
    logic signed [CW-1:0]     c1;
    // S2
    logic                     v2, f2, l2;
    logic [CH_W-1:0]          ch2;
    logic signed [PW-1:0]     p2;
    // S3
    logic [ACC_W-1:0]         acc [NCH];
    logic                     v3;
    logic [CH_W-1:0]          ch3;
    // S4
    logic                     v4;
    logic [CH_W-1:0]          ch4;
    logic [ACC_W-1:0]         sum4;
    logic [OW-1:0]            rs_dout;
    logic                     rs_ovf;

    assign accept = iv && ({1'b0, ch} < NCH_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            f1  <= 1'b0;
            l1  <= 1'b0;
            ch1 <= '0;
            d1  <= '0;
            c1  <= '0;
            v2  <= 1'b0;
            f2  <= 1'b0;
            l2  <= 1'b0;
            ch2 <= '0;
            p2  <= '0;
            v3  <= 1'b0;
            ch3 <= '0;
            v4  <= 1'b0;
            ch4 <= '0;
            sum4 <= '0;
            dout <= '0;
            och  <= '0;
            ov   <= 1'b0;
            ovf  <= 1'b0;
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
        end else begin
            // S1: capture the sample.
            v1  <= accept;
            f1  <= first;
            l1  <= last;
            ch1 <= ch;
            d1  <= $signed(din);
            c1  <= $signed(cin);
            // S2: full-width signed product.
            v2  <= v1;
            f2  <= f1;
            l2  <= l1;
            ch2 <= ch1;
            p2  <= PW'(d1) * PW'(c1);
            // S3: read-modify-write of the channel sum within one stage, so
            // consecutive taps on one channel need no forwarding.
            if (v2) begin
                acc[ch2] <= (f2 ? '0 : acc[ch2]) + ACC_W'(p2);
            end
            v3  <= v2 && l2;
            ch3 <= ch2;
            // S4a: fetch the finished sum so rounding stays off the accumulator loop.
            v4   <= v3;
            ch4  <= ch3;
            sum4 <= acc[ch3];
            // S4b: round/saturate and hold outputs until the next result.
            ov <= v4;
            if (v4) begin
                dout <= rs_dout;
                och  <= ch4;
                ovf  <= rs_ovf;
            end
        end
    end

    mac_round_sat #(
        .IW     (ACC_W),
        .OW     (OW),
        .OSHIFT (OSHIFT)
    ) u_round_sat (
        .acc  (sum4),
        .dout (rs_dout),
        .ovf  (rs_ovf)
    );

endmodule

// File: tb/tb_mac_nch_acc.sv
// Self-checking bench for mac_nch_acc: directed cases plus random traffic,
// checked against a per-channel arithmetic model.
module tb_mac_nch_acc;

    localparam int DW     = 18;
    localparam int CW     = 28;
    localparam int NCH    = 4;
    localparam int CHW    = 2;
    localparam int AW     = 48;
    localparam int OSHIFT = 24;
    localparam int OW     = 20;
    localparam int LAT    = 5; // negedge count from presenting a sample to its result

    logic            clk = 1'b0;
    logic            rst;
    logic            iv, first, last;
    logic [DW-1:0]   din;
    logic [CW-1:0]   cin;
    logic [CHW-1:0]  ch;
    logic [OW-1:0]   dout;
    logic [CHW-1:0]  och;
    logic            ov, ovf;

    always #5 clk = ~clk;

    mac_nch_acc dut (
        .clk   (clk),
        .rst   (rst),
        .iv    (iv),
        .din   (din),
        .cin   (cin),
        .ch    (ch),
        .first (first),
        .last  (last),
        .dout  (dout),
        .och   (och),
        .ov    (ov),
        .ovf   (ovf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint due;
        longint chan;
        longint val;
        longint of;
    } exp_t;

    exp_t   expq[$];
    longint model_acc[NCH];
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint wrap_aw(input longint a);
        return (a <<< (64 - AW)) >>> (64 - AW);
    endfunction

    function automatic void expect_of(input longint a, output longint val, output longint of);
        longint scale, half, q, base, rem, lim;
        scale = 64'sd1 <<< OSHIFT;
        half  = scale / 2;
`ifdef MAC_CONV_ROUND_EN
        base = a >>> OSHIFT;           // floor
        rem  = a - base * scale;
        if (rem > half)       q = base + 1;
        else if (rem == half) q = base + (base & 1);
        else                  q = base;
`else
        if (a >= 0) q = (a + half) / scale;
        else        q = -((-a + half) / scale);
`endif
        lim = (64'sd1 <<< (OW - 1)) - 1;
        if (q > lim || q < -lim - 1) begin
            of  = 1;
            val = (a < 0) ? -lim : lim;
        end else begin
            of  = 0;
            val = q;
        end
    endfunction

    always @(negedge clk) begin
        exp_t   e;
        bit     due;
        longint p;
        if (rst) begin
            check_eq("ov_in_reset", longint'(ov), 0);
            expq.delete();
            for (int i = 0; i < NCH; i++) model_acc[i] = 0;
        end else begin
            due = (expq.size() > 0) && (expq[0].due == cyc);
            check_eq("ov_timing", longint'(ov), longint'(due));
            if (due) begin
                e = expq.pop_front();
                if (ov) begin
                    check_eq("och",  longint'(och), e.chan);
                    check_eq("dout", longint'($signed(dout)), e.val);
                    check_eq("ovf",  longint'(ovf), e.of);
                end
            end
            if (iv && int'(ch) < NCH) begin
                p = longint'($signed(din)) * longint'($signed(cin));
                model_acc[ch] = wrap_aw(first ? p : model_acc[ch] + p);
                if (last) begin
                    e.due  = cyc + LAT;
                    e.chan = longint'(ch);
                    expect_of(model_acc[ch], e.val, e.of);
                    expq.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit v, input int c, input longint d, input longint co,
                        input bit f, input bit l);
        @(posedge clk);
        #1;
        iv    = v;
        ch    = c[CHW-1:0];
        din   = d[DW-1:0];
        cin   = co[CW-1:0];
        first = f;
        last  = l;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        iv  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam longint ONE = 64'sd1 <<< 24;

    initial begin
        rst = 1'b1;
        iv = 1'b0; first = 1'b0; last = 1'b0; din = '0; cin = '0; ch = '0;
        #1;
        check_eq("rst_dout", longint'(dout), 0);
        check_eq("rst_och",  longint'(och), 0);
        check_eq("rst_ov",   longint'(ov), 0);
        check_eq("rst_ovf",  longint'(ovf), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single tap.
        send(1, 2, 1000, ONE, 1, 1);
        idle(6);

        // Rounding ties.
        send(1, 0, 1, ONE / 2, 1, 1);
        send(1, 1, -1, ONE / 2, 1, 1);
        send(1, 2, 3, ONE / 2, 1, 1);
        send(1, 3, 1, ONE / 2 - 1, 1, 1);
        idle(6);

        // Interleaved ch0/ch1.
        for (int i = 0; i < 16; i++)
            send(1, i % 2, (i % 2) ? -1 : 1, ONE, i < 2, i >= 14);
        idle(6);

        // Same-channel back-to-back, then an immediate single-tap restart.
        for (int i = 0; i < 16; i++) send(1, 3, 3, ONE, i == 0, i == 15);
        send(1, 3, 5, ONE, 1, 1);
        idle(6);

        // Saturation, both signs.
        for (int i = 0; i < 8; i++) send(1, 0, 131071, (64'sd1 <<< 27) - 1, i == 0, i == 7);
        for (int i = 0; i < 8; i++) send(1, 1, -131072, (64'sd1 <<< 27) - 1, i == 0, i == 7);
        idle(6);

        // Reset mid-sum, then a last-only tap on the cleared accumulator.
        for (int i = 0; i < 3; i++) send(1, 1, 11, ONE, i == 0, 1'b0);
        do_reset(3);
        idle(1);
        send(1, 1, 7, ONE, 0, 1);
        idle(6);

        // Random traffic, mixed magnitudes, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            longint d, c;
            d = ($urandom % 2) ? longint'($urandom) : longint'($urandom_range(0, 63)) - 32;
            c = ($urandom % 2) ? longint'($urandom) : longint'($urandom_range(0, 1 << 26));
            send($urandom % 4 != 0, $urandom % NCH, d, c, $urandom % 4 == 0, $urandom % 3 == 0);
            if (i == 300) do_reset(2);
        end
        idle(8);
        check_eq("pending_results", longint'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
